// File: rtl/trojan_resp_checker.sv
// ---------------------------------------------------------------------------
// trojan_resp_checker
//
// Purpose:
//   Compares the single-bit responses of a device under test against a
//   programmable golden table. It counts mismatches, remembers the first
//   failing pattern and tracks which patterns have been seen. A run
//   completes once every pattern has been seen at least once.
//
// Optional feature:
//   RESP_SIGNATURE_EN - when defined, a 16-bit MISR (x^16+x^12+x^5+1)
//   compresses {in_pattern,in_resp} of every valid sample into 'signature'.
//   When undefined, 'signature' is tied to zero and no MISR is built.
//
// Ports:
//   CK               - clock; all state updates on its rising edge
//   reset            - asynchronous active-high reset (also clears the table)
//   start            - begins a run from IDLE or DONE; ignored in CHECK
//   golden_wr        - golden table write strobe (ignored in CHECK)
//   golden_addr      - golden table write address
//   golden_data      - expected response written to golden_addr
//   in_valid         - qualifies in_pattern/in_resp (only used in CHECK)
//   in_pattern       - pattern applied to the device under test
//   in_resp          - observed response for in_pattern
//   busy             - high while in CHECK
//   done             - high while in DONE
//   pass             - high in DONE when no mismatch was counted
//   mismatch_cnt     - saturating count of mismatching samples
//   first_fail_valid - set by the first mismatch of a run
//   first_fail_pat   - pattern of the first mismatch of a run
//   coverage         - one bit per pattern seen in the current run
//   signature        - MISR signature (zero without RESP_SIGNATURE_EN)
// ---------------------------------------------------------------------------
module trojan_resp_checker #(
    parameter int PAT_W = 4
) (
    input  logic                    CK,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    golden_wr,
    input  logic [PAT_W-1:0]        golden_addr,
    input  logic                    golden_data,
    input  logic                    in_valid,
    input  logic [PAT_W-1:0]        in_pattern,
    input  logic                    in_resp,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [PAT_W:0]          mismatch_cnt,
    output logic                    first_fail_valid,
    output logic [PAT_W-1:0]        first_fail_pat,
    output logic [(2**PAT_W)-1:0]   coverage,
    output logic [15:0]             signature
);

    localparam int NPAT = 2 ** PAT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [NPAT-1:0]     golden_q, golden_d;
    logic [PAT_W:0]      cnt_q, cnt_d;
    logic                ffv_q, ffv_d;
    logic [PAT_W-1:0]    ffp_q, ffp_d;
    logic [NPAT-1:0]     cov_q, cov_d;

    logic                start_run_s;
    logic                sample_s;
    logic                mismatch_s;

    // A run (re)starts only from IDLE or DONE; samples count only in CHECK.
    assign start_run_s = start && (state_q != CHECK);
    assign sample_s    = in_valid && (state_q == CHECK);
    assign mismatch_s  = sample_s && (in_resp != golden_q[in_pattern]);

    // Next-state logic: leave CHECK one cycle after coverage fills up.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = CHECK;
                else       state_d = IDLE;
            end
            CHECK: begin
                if (&cov_q) state_d = DONE;
                else        state_d = CHECK;
            end
            DONE: begin
                if (start) state_d = CHECK;
                else       state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Golden table writes are accepted only while no run is in progress.
    always_comb begin
        golden_d = golden_q;
        if (golden_wr && (state_q != CHECK)) begin
            golden_d[golden_addr] = golden_data;
        end else begin
            golden_d = golden_q;
        end
    end

    // Run statistics: cleared on start, updated per valid CHECK sample.
    always_comb begin
        cnt_d = cnt_q;
        ffv_d = ffv_q;
        ffp_d = ffp_q;
        cov_d = cov_q;
        if (start_run_s) begin
            cnt_d = '0;
            ffv_d = 1'b0;
            ffp_d = '0;
            cov_d = '0;
        end else if (sample_s) begin
            cov_d[in_pattern] = 1'b1;
            if (mismatch_s) begin
                // Saturate rather than wrap so a flood of failures stays visible.
                if (&cnt_q) cnt_d = cnt_q;
                else        cnt_d = cnt_q + {{PAT_W{1'b0}}, 1'b1};
                if (!ffv_q) begin
                    ffv_d = 1'b1;
                    ffp_d = in_pattern;
                end else begin
                    ffv_d = ffv_q;
                    ffp_d = ffp_q;
                end
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cov_d = cov_q;
        end
    end

    // State and run-statistic registers.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            golden_q <= '0;
            cnt_q    <= '0;
            ffv_q    <= 1'b0;
            ffp_q    <= '0;
            cov_q    <= '0;
        end else begin
            state_q  <= state_d;
            golden_q <= golden_d;
            cnt_q    <= cnt_d;
            ffv_q    <= ffv_d;
            ffp_q    <= ffp_d;
            cov_q    <= cov_d;
        end
    end

    assign busy             = (state_q == CHECK);
    assign done             = (state_q == DONE);
    assign pass             = (state_q == DONE) && (cnt_q == '0);
    assign mismatch_cnt     = cnt_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_pat   = ffp_q;
    assign coverage         = cov_q;

`ifdef RESP_SIGNATURE_EN
    logic [15:0] sig_q, sig_d;
    logic [15:0] misr_in_s;

    // One MISR step: Galois shift with feedback taps 0x1021, then fold in data.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
    endfunction

    assign misr_in_s = {{(15 - PAT_W){1'b0}}, in_pattern, in_resp};

    // Signature clears on start and absorbs each valid CHECK sample.
    always_comb begin
        sig_d = sig_q;
        if (start_run_s) sig_d = 16'h0000;
        else if (sample_s) sig_d = misr_step(sig_q, misr_in_s);
        else sig_d = sig_q;
    end

    // Signature register.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) sig_q <= 16'h0000;
        else       sig_q <= sig_d;
    end

    assign signature = sig_q;
`else
    assign signature = 16'h0000;
`endif

endmodule
